mano_dr_ctrl: RTL and testbench

//  Second-generation data-register (DR) unit for the Mano basic computer: owns the DR and its own sequencing.
//  On an accepted memory-reference instruction it fetches the operand into DR, and for ISZ also

---
 rtl/mano_dr_ctrl.sv | 141 ++++++++++++++
 tb/tb_mano_dr_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mano_dr_ctrl.sv
// Data-register unit for the Mano basic computer: fetches operands into DR and,
// for ISZ, increments DR, writes it back and reports whether the result was zero.
module mano_dr_ctrl #(
    parameter int          WIDTH       = 16,
    parameter logic [7:0]  LOAD_MASK   = 8'b0100_0111,
    parameter int          ISZ_OP      = 6,
    parameter bit          CLR_ON_IDLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_vld,
    output logic             instr_rdy,
    input  logic [7:0]       D,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_rvld,
    output logic             rd_req,
    output logic             wr_req,
    input  logic             wr_ack,
    output logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] dr_q,
    output logic             LD,
    output logic             INC,
    output logic             CLR,
    output logic [7:0]       T,
    output logic             skip,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_INC   = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             isz_q, isz_d;
    logic [WIDTH-1:0] dr_d;

    // State, latched ISZ flag and DR register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            isz_q   <= 1'b0;
            dr_q    <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            isz_q   <= isz_d;
            dr_q    <= dr_d;
        end
    end

    // Next-state and DR datapath; only the ISZ bit of D matters after acceptance
    always_comb begin
        state_d = state_q;
        isz_d   = isz_q;
        dr_d    = dr_q;
        case (state_q)
            S_IDLE: begin
                if (instr_vld) begin
                    isz_d   = D[ISZ_OP];
                    state_d = ((D & LOAD_MASK) != 8'd0) ? S_READ : S_FIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (mem_rvld) begin
                    dr_d    = mem_rdata;
                    state_d = isz_q ? S_INC : S_FIN;
                end else begin
                    state_d = S_READ;
                end
            end
            S_INC: begin
                dr_d    = dr_q + {{(WIDTH-1){1'b0}}, 1'b1};
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_ack) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_FIN: begin
                if (CLR_ON_IDLE) begin
                    dr_d = {WIDTH{1'b0}};
                end else begin
                    dr_d = dr_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes, requests and timing decoded from the current state
    always_comb begin
        instr_rdy = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        LD        = 1'b0;
        INC       = 1'b0;
        CLR       = 1'b0;
        T         = 8'd0;
        skip      = 1'b0;
        done      = 1'b0;
        wr_data   = dr_q;
        case (state_q)
            S_IDLE: begin
                instr_rdy = 1'b1;
            end
            S_READ: begin
                rd_req = 1'b1;
                T[4]   = 1'b1;
                LD     = mem_rvld;
            end
            S_INC: begin
                T[5] = 1'b1;
                INC  = 1'b1;
            end
            S_WRITE: begin
                wr_req = 1'b1;
                T[6]   = 1'b1;
                skip   = wr_ack && (dr_q == {WIDTH{1'b0}});
            end
            S_FIN: begin
                done = 1'b1;
                CLR  = CLR_ON_IDLE;
            end
            default: begin
                instr_rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mano_dr_ctrl.sv
// Scoreboard bench for mano_dr_ctrl: a driver pushes hand-computed expectations,
// a negedge monitor pops one per done pulse and compares the observed instruction.
module tb_mano_dr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_vld = 1'b0;
    logic [7:0]  D = 8'd0;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_rvld = 1'b0;
    logic        wr_ack = 1'b0;

    logic        instr_rdy, rd_req, wr_req, LD, INC, CLR, skip, done;
    logic [15:0] wr_data, dr_q;
    logic [7:0]  T;
    logic        instr_rdy_c, rd_req_c, wr_req_c, ld_c, inc_c, clr_c, skip_c, done_c;
    logic [15:0] wr_data_c, dr_c;
    logic [7:0]  t_c;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          lat;
        logic [15:0] dr;
        logic [15:0] drc;
        int          nld;
        int          ninc;
        int          nwr;
        logic [15:0] wrd;
        logic        skip;
        logic        rd;
    } exp_t;

    exp_t exp_q[$];

    mano_dr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_vld(instr_vld), .instr_rdy(instr_rdy), .D(D),
        .mem_rdata(mem_rdata), .mem_rvld(mem_rvld), .rd_req(rd_req), .wr_req(wr_req),
        .wr_ack(wr_ack), .wr_data(wr_data), .dr_q(dr_q), .LD(LD), .INC(INC), .CLR(CLR),
        .T(T), .skip(skip), .done(done)
    );

    mano_dr_ctrl #(.CLR_ON_IDLE(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .instr_vld(instr_vld), .instr_rdy(instr_rdy_c), .D(D),
        .mem_rdata(mem_rdata), .mem_rvld(mem_rvld), .rd_req(rd_req_c), .wr_req(wr_req_c),
        .wr_ack(wr_ack), .wr_data(wr_data_c), .dr_q(dr_c), .LD(ld_c), .INC(inc_c), .CLR(clr_c),
        .T(t_c), .skip(skip_c), .done(done_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic [15:0] dr, input logic [15:0] drc,
                                input int nld, input int ninc, input int nwr,
                                input logic [15:0] wrd, input logic sk, input logic rd);
        exp_t e;
        e.lat = lat; e.dr = dr; e.drc = drc; e.nld = nld; e.ninc = ninc;
        e.nwr = nwr; e.wrd = wrd; e.skip = sk; e.rd = rd;
        return e;
    endfunction

    // Monitor: tracks one instruction from acceptance to done and scores it
    logic        act_m = 1'b0;
    logic        pc_m = 1'b0;
    int          cyc_m, nld_m, ninc_m, nwr_m;
    logic [15:0] wrd_m;
    logic        sk_m, rd_m;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            act_m = 1'b0;
            pc_m  = 1'b0;
        end else begin
            checks++;
            if (!($onehot0(T) && $onehot0({LD, INC, CLR}) && !CLR && $onehot0({ld_c, inc_c, clr_c}))) begin
                failures++;
                $display("FAIL exclusivity T=%0h ld/inc/clr=%b%b%b", T, LD, INC, CLR);
            end
            if (pc_m) begin
                chk("drc_after_fin", dr_c, 32'd0);
                pc_m = 1'b0;
            end
            if (instr_vld && instr_rdy) begin
                act_m = 1'b1; cyc_m = 1; nld_m = 0; ninc_m = 0; nwr_m = 0;
                wrd_m = 16'd0; sk_m = 1'b0; rd_m = 1'b0;
            end else if (act_m) begin
                cyc_m++;
                nld_m  += int'(LD);
                ninc_m += int'(INC);
                if (wr_req) nwr_m++;
                if (wr_req && wr_ack) wrd_m = wr_data;
                sk_m = sk_m | skip;
                rd_m = rd_m | rd_req;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency", cyc_m, e.lat);
                        chk("dr_q", dr_q, e.dr);
                        chk("ld_count", nld_m, e.nld);
                        chk("inc_count", ninc_m, e.ninc);
                        chk("wr_cycles", nwr_m, e.nwr);
                        if (e.nwr != 0) chk("wr_data", wrd_m, e.wrd);
                        chk("skip", sk_m, e.skip);
                        chk("rd_req_seen", rd_m, e.rd);
                        chk("clr_pulse", {done_c, clr_c}, 2'b11);
                        chk("drc_at_fin", dr_c, e.drc);
                    end
                    act_m = 1'b0;
                    pc_m  = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [7:0] d, input logic [15:0] rdata, input int rdly,
                         input int adly, input bit hold, input bit spur, input exp_t e);
        int  nr = 0;
        int  nw = 0;
        bit  fin = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        instr_vld = 1'b1; D = d; mem_rdata = rdata;
        @(posedge clk); #1;
        if (!hold) instr_vld = 1'b0;
        for (int k = 0; k < 60; k++) begin
            mem_rvld = rd_req && (nr == rdly);
            wr_ack   = (wr_req && (nw == adly)) || (spur && rd_req);
            if (done) begin
                fin = 1'b1;
                break;
            end
            if (rd_req) nr++;
            if (wr_req) nw++;
            @(posedge clk); #1;
        end
        instr_vld = 1'b0; mem_rvld = 1'b0; wr_ack = 1'b0;
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #3;
        chk("rst_rdy", {instr_rdy, rd_req, wr_req, done, skip}, 5'b10000);
        chk("rst_dr", dr_q, 32'd0);
        chk("rst_T", T, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // LDA, operand one cycle after READ entry
        issue(8'h04, 16'h1234, 1, 0, 1'b0, 1'b0, mk(4, 16'h1234, 16'h1234, 1, 0, 0, 16'h0, 1'b0, 1'b1));
        // ISZ wrapping to zero -> skip
        issue(8'h40, 16'hFFFF, 0, 0, 1'b0, 1'b0, mk(5, 16'h0000, 16'h0000, 1, 1, 1, 16'h0000, 1'b1, 1'b1));
        // ISZ with write ack delayed 3 cycles
        issue(8'h40, 16'h0005, 0, 3, 1'b0, 1'b0, mk(8, 16'h0006, 16'h0006, 1, 1, 4, 16'h0006, 1'b0, 1'b1));
        // Non-load opcodes leave DR alone
        issue(8'h80, 16'hDEAD, 0, 0, 1'b0, 1'b0, mk(2, 16'h0006, 16'h0000, 0, 0, 0, 16'h0, 1'b0, 1'b0));
        issue(8'h00, 16'hDEAD, 0, 0, 1'b0, 1'b0, mk(2, 16'h0006, 16'h0000, 0, 0, 0, 16'h0, 1'b0, 1'b0));
        // instr_vld held and spurious wr_ack during READ
        issue(8'h04, 16'hA5A5, 2, 0, 1'b1, 1'b1, mk(5, 16'hA5A5, 16'hA5A5, 1, 0, 0, 16'h0, 1'b0, 1'b1));
        // Multi-bit D with ISZ bit set takes the ISZ path
        issue(8'h41, 16'h7FFF, 0, 0, 1'b0, 1'b0, mk(5, 16'h8000, 16'h8000, 1, 1, 1, 16'h8000, 1'b0, 1'b1));
        issue(8'h03, 16'h0F0F, 0, 0, 1'b0, 1'b0, mk(3, 16'h0F0F, 16'h0F0F, 1, 0, 0, 16'h0, 1'b0, 1'b1));

        // Reset in the middle of READ
        @(posedge clk); #1;
        instr_vld = 1'b1; D = 8'h04;
        @(posedge clk); #1;
        instr_vld = 1'b0;
        chk("pre_rst_rd_req", rd_req, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_req", {rd_req, rd_req_c}, 32'd0);
        chk("mid_rst_dr", dr_q, 32'd0);
        chk("mid_rst_T", T, 32'd0);
        chk("mid_rst_rdy", instr_rdy, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(8'h04, 16'hBEEF, 0, 0, 1'b0, 1'b0, mk(3, 16'hBEEF, 16'hBEEF, 1, 0, 0, 16'h0, 1'b0, 1'b1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
